game_control_fsm: RTL and testbench
===================================

// Module: game_control_fsm
// PURPOSE
//   Top-level sequencer for the game datapath. Steps it once per frame through
//   init, idle/frame pacing, move generation, collision check, action apply,
//   map/link/enemy draw into the frame buffer and frame-buffer-to-VGA copy.
//   Drives one strobe per phase, waits on the matching done flag, and guards
//   every wait with a watchdog.
// PARAMETERS
//   INIT_CYCLES   4      cycles init is held after reset release (>=1)
//   APPLY_CYCLES  2      fixed length of APPLY_LINK and MOVE_ENEMIES (no done flag)
//   TIMEOUT       20'hFFFFF  max cycles in any done-gated state before abort
// PORTS
//   clock               in   1   system clock (CLOCK_50)
//   reset               in   1   asynchronous, active-low reset
//   pause               in   1   hold in IDLE at frame boundary while high
//   idle_done           in   1   frame pacing elapsed
//   gen_move_done       in   1   enemy move generation finished
//   check_collide_done  in   1   collision detector finished
//   draw_map_done       in   1   map written to frame buffer
//   draw_link_done      in   1   link sprite written
//   draw_enemies_done   in   1   enemy sprites written
//   draw_vga_done       in   1   frame buffer copied to VGA memory
//   init, idle, gen_move, check_collide, apply_act_link, move_enemies,
//   draw_map, draw_link, draw_enemies, draw_to_vga   out 1 each  phase strobes
//   frame_count         out  16  completed frames, wraps 16'hFFFF -> 0
//   timeout_err         out  1   sticky: a watchdog expired since reset
//   err_state           out  4   state code that timed out (last one)
// BEHAVIOUR
//   - Reset (reset=0, async): state=S_INIT, counters 0, all strobes 0 except init=1,
//     frame_count=0, timeout_err=0, err_state=0. Reset mid-frame aborts at once.
//   - Moore machine; strobes decoded from state register, exactly one high always.
//   - States/codes: S_INIT 0, S_IDLE 1, S_GEN_MOVE 2, S_CHECK_COLLIDE 3,
//     S_APPLY_LINK 4, S_MOVE_ENEMIES 5, S_DRAW_MAP 6, S_DRAW_LINK 7,
//     S_DRAW_ENEMIES 8, S_DRAW_VGA 9; codes 10-15 -> S_INIT next cycle.
//   - S_INIT: held INIT_CYCLES cycles, then S_IDLE.
//   - S_IDLE: leave to S_GEN_MOVE when idle_done=1 and pause=0; pause=1 blocks
//     even if idle_done high; no watchdog in IDLE.
//   - Done-gated states (GEN_MOVE, CHECK_COLLIDE, DRAW_MAP, DRAW_LINK,
//     DRAW_ENEMIES, DRAW_VGA): done sampled on each clock while in the state,
//     including entry cycle; done=1 -> next state on that edge. Order:
//     GEN_MOVE->CHECK_COLLIDE->APPLY_LINK->MOVE_ENEMIES->DRAW_MAP->DRAW_LINK->
//     DRAW_ENEMIES->DRAW_VGA->IDLE.
//   - APPLY_LINK, MOVE_ENEMIES: exactly APPLY_CYCLES cycles each, no done input.
//   - Dwell counter (20 bit) clears on every state change. In a done-gated state,
//     if count reaches TIMEOUT-1 with done still 0: timeout_err<=1,
//     err_state<=state code, next state S_IDLE (frame dropped, frame_count
//     unchanged). Done and timeout on same cycle: done wins.
//   - frame_count increments on the DRAW_VGA->IDLE edge only.
//   - Done inputs seen outside their own state are ignored.
//   - timeout_err cleared only by reset.
// TESTING
//   1 Reset low 3 cycles, release -> init=1 for 4 cycles, then idle=1; all other strobes 0.
//   2 Every done pulsed 1 cycle after entry -> full frame visits states 1,2,3,4,4,5,5,6..9,1;
//     frame_count 0->1; timeout_err=0.
//   3 pause=1 with idle_done=1 for 50 cycles -> stays S_IDLE; pause=0 -> gen_move=1 next cycle.
//   4 TIMEOUT=16, draw_link_done held 0 -> after 16 cycles in S_DRAW_LINK: idle=1,
//     timeout_err=1, err_state=7, frame_count unchanged.
//   5 draw_map_done held high from GEN_MOVE onward -> ignored early; DRAW_MAP lasts 1 cycle.
//   6 Reset asserted mid-DRAW_VGA -> same edge-free async return to init=1, frame_count=0.
//   7 frame_count preset by running 65536 frames (short bench) -> wraps to 0.

Source files
------------

// File: rtl/game_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : game_control_fsm
//  Purpose  : Per-frame sequencer for the game datapath. Steps through init,
//             frame pacing, move generation, collision check, action apply,
//             sprite/map drawing and the frame-buffer-to-VGA copy. One strobe
//             per phase, each done-gated phase guarded by a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module game_control_fsm #(
  parameter int unsigned INIT_CYCLES  = 4,
  parameter int unsigned APPLY_CYCLES = 2,
  parameter logic [19:0] TIMEOUT      = 20'hFFFFF,
  // Last frame_count value before it rolls over to zero.
  parameter logic [15:0] FRAME_WRAP   = 16'hFFFF
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        pause_i,
  input  logic        idle_done_i,
  input  logic        gen_move_done_i,
  input  logic        check_collide_done_i,
  input  logic        draw_map_done_i,
  input  logic        draw_link_done_i,
  input  logic        draw_enemies_done_i,
  input  logic        draw_vga_done_i,
  output logic        init_o,
  output logic        idle_o,
  output logic        gen_move_o,
  output logic        check_collide_o,
  output logic        apply_act_link_o,
  output logic        move_enemies_o,
  output logic        draw_map_o,
  output logic        draw_link_o,
  output logic        draw_enemies_o,
  output logic        draw_to_vga_o,
  output logic [15:0] frame_count_o,
  output logic        timeout_err_o,
  output logic [3:0]  err_state_o
);

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_APPLY_LINK    = 4'd4,
    S_MOVE_ENEMIES  = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENEMIES  = 4'd8,
    S_DRAW_VGA      = 4'd9
  } state_e;

  localparam logic [19:0] INIT_LAST    = 20'(INIT_CYCLES - 1);
  localparam logic [19:0] APPLY_LAST   = 20'(APPLY_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = TIMEOUT - 20'd1;

  state_e      state_q, state_d;
  logic [19:0] dwell_q, dwell_d;
  logic [15:0] frame_q, frame_d;
  logic        terr_q, terr_d;
  logic [3:0]  errst_q, errst_d;

  // Per-state helpers for the shared done/watchdog handling.
  logic        gated_w;
  logic        done_w;
  state_e      gated_next_w;

  // State, dwell counter, frame counter and sticky error registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_INIT;
      dwell_q <= '0;
      frame_q <= '0;
      terr_q  <= 1'b0;
      errst_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      frame_q <= frame_d;
      terr_q  <= terr_d;
      errst_q <= errst_d;
    end
  end

  // Next-state, watchdog and frame-count logic.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    terr_d       = terr_q;
    errst_d      = errst_q;
    gated_w      = 1'b0;
    done_w       = 1'b0;
    gated_next_w = S_IDLE;

    case (state_q)
      S_INIT: begin
        if (dwell_q == INIT_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Pause has priority so the game freezes on a frame boundary.
        if (idle_done_i && !pause_i) state_d = S_GEN_MOVE;
      end
      S_GEN_MOVE: begin
        gated_w      = 1'b1;
        done_w       = gen_move_done_i;
        gated_next_w = S_CHECK_COLLIDE;
      end
      S_CHECK_COLLIDE: begin
        gated_w      = 1'b1;
        done_w       = check_collide_done_i;
        gated_next_w = S_APPLY_LINK;
      end
      S_APPLY_LINK: begin
        if (dwell_q == APPLY_LAST) state_d = S_MOVE_ENEMIES;
      end
      S_MOVE_ENEMIES: begin
        if (dwell_q == APPLY_LAST) state_d = S_DRAW_MAP;
      end
      S_DRAW_MAP: begin
        gated_w      = 1'b1;
        done_w       = draw_map_done_i;
        gated_next_w = S_DRAW_LINK;
      end
      S_DRAW_LINK: begin
        gated_w      = 1'b1;
        done_w       = draw_link_done_i;
        gated_next_w = S_DRAW_ENEMIES;
      end
      S_DRAW_ENEMIES: begin
        gated_w      = 1'b1;
        done_w       = draw_enemies_done_i;
        gated_next_w = S_DRAW_VGA;
      end
      S_DRAW_VGA: begin
        gated_w      = 1'b1;
        done_w       = draw_vga_done_i;
        gated_next_w = S_IDLE;
      end
      default: begin
        // Unused encodings recover through a full init.
        state_d = S_INIT;
      end
    endcase

    // Done beats the watchdog when both land on the same cycle; a timeout
    // drops the frame without touching frame_count.
    if (gated_w) begin
      if (done_w) begin
        state_d = gated_next_w;
        if (state_q == S_DRAW_VGA) begin
          frame_d = (frame_q == FRAME_WRAP) ? 16'd0 : frame_q + 16'd1;
        end
      end else if (dwell_q == TIMEOUT_LAST) begin
        state_d = S_IDLE;
        terr_d  = 1'b1;
        errst_d = state_q;
      end
    end

    dwell_d = (state_d != state_q) ? 20'd0 : dwell_q + 20'd1;
  end

  // Moore strobe decode: exactly one phase strobe follows the state register.
  always_comb begin
    init_o           = 1'b0;
    idle_o           = 1'b0;
    gen_move_o       = 1'b0;
    check_collide_o  = 1'b0;
    apply_act_link_o = 1'b0;
    move_enemies_o   = 1'b0;
    draw_map_o       = 1'b0;
    draw_link_o      = 1'b0;
    draw_enemies_o   = 1'b0;
    draw_to_vga_o    = 1'b0;
    case (state_q)
      S_INIT:          init_o           = 1'b1;
      S_IDLE:          idle_o           = 1'b1;
      S_GEN_MOVE:      gen_move_o       = 1'b1;
      S_CHECK_COLLIDE: check_collide_o  = 1'b1;
      S_APPLY_LINK:    apply_act_link_o = 1'b1;
      S_MOVE_ENEMIES:  move_enemies_o   = 1'b1;
      S_DRAW_MAP:      draw_map_o       = 1'b1;
      S_DRAW_LINK:     draw_link_o      = 1'b1;
      S_DRAW_ENEMIES:  draw_enemies_o   = 1'b1;
      S_DRAW_VGA:      draw_to_vga_o    = 1'b1;
      default:         init_o           = 1'b1;
    endcase
  end

  assign frame_count_o = frame_q;
  assign timeout_err_o = terr_q;
  assign err_state_o   = errst_q;

endmodule
`default_nettype wire

// File: tb/tb_game_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_control_fsm
//  Purpose  : Self-checking bench for game_control_fsm (short watchdog and
//             small frame wrap value so every corner fits in a short run).
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_control_fsm;

  localparam logic [19:0] TB_TIMEOUT = 20'd16;
  localparam logic [15:0] TB_WRAP    = 16'd3;

  logic        clk;
  logic        rst_n;
  logic        pause, idle_done, gen_d, chk_d, map_d, link_d, ene_d, vga_d;
  logic [9:0]  strobes;
  logic [15:0] frame_count;
  logic        timeout_err;
  logic [3:0]  err_state;

  game_control_fsm #(
    .INIT_CYCLES (4),
    .APPLY_CYCLES(2),
    .TIMEOUT     (TB_TIMEOUT),
    .FRAME_WRAP  (TB_WRAP)
  ) dut (
    .clock_i             (clk),
    .reset_ni            (rst_n),
    .pause_i             (pause),
    .idle_done_i         (idle_done),
    .gen_move_done_i     (gen_d),
    .check_collide_done_i(chk_d),
    .draw_map_done_i     (map_d),
    .draw_link_done_i    (link_d),
    .draw_enemies_done_i (ene_d),
    .draw_vga_done_i     (vga_d),
    .init_o              (strobes[0]),
    .idle_o              (strobes[1]),
    .gen_move_o          (strobes[2]),
    .check_collide_o     (strobes[3]),
    .apply_act_link_o    (strobes[4]),
    .move_enemies_o      (strobes[5]),
    .draw_map_o          (strobes[6]),
    .draw_link_o         (strobes[7]),
    .draw_enemies_o      (strobes[8]),
    .draw_to_vga_o       (strobes[9]),
    .frame_count_o       (frame_count),
    .timeout_err_o       (timeout_err),
    .err_state_o         (err_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input byte: [7] pause [6] idle_done [5] gen [4] chk [3] map [2] link [1] ene [0] vga
  typedef struct {
    logic [7:0]  in;
    logic [3:0]  st;
    logic [15:0] fc;
    logic        te;
    logic [3:0]  es;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] fc;
    logic        te;
    logic [3:0]  es;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [7:0] in, input logic [3:0] st,
                              input logic [15:0] fc, input logic te,
                              input logic [3:0] es);
    vec_t v;
    v.in = in; v.st = st; v.fc = fc; v.te = te; v.es = es;
    return v;
  endfunction

  // One-hot strobe vector to state code; 15 flags "not exactly one high".
  function automatic logic [3:0] enc(input logic [9:0] s);
    int cnt;
    logic [3:0] code;
    cnt  = 0;
    code = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (s[i]) begin
        cnt++;
        code = 4'(i);
      end
    end
    return (cnt == 1) ? code : 4'hF;
  endfunction

  task automatic drive(input logic [7:0] v);
    {pause, idle_done, gen_d, chk_d, map_d, link_d, ene_d, vga_d} = v;
  endtask

  task automatic push(input logic [3:0] st, input logic [15:0] fc,
                      input logic te, input logic [3:0] es);
    exp_t e;
    e.st = st; e.fc = fc; e.te = te; e.es = es;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    logic [3:0] act;
    e   = sb.pop_front();
    act = enc(strobes);
    n_checks++;
    if (act !== e.st || frame_count !== e.fc || timeout_err !== e.te ||
        err_state !== e.es) begin
      n_fail++;
      $display("FAIL %s @%0t: got state=%0d frame=%0d terr=%0b errst=%0d, want state=%0d frame=%0d terr=%0b errst=%0d",
               name, $time, act, frame_count, timeout_err, err_state,
               e.st, e.fc, e.te, e.es);
    end
  endtask

  // Drive one cycle of inputs, expect the outputs after the next rising edge.
  task automatic cyc(input string name, input logic [7:0] v, input logic [3:0] st,
                     input logic [15:0] fc, input logic te, input logic [3:0] es);
    drive(v);
    push(st, fc, te, es);
    @(posedge clk);
    #1;
    check(name);
  endtask

  // A frame with every done held high: 11 cycles, IDLE back to IDLE.
  task automatic quick_frame(input logic [15:0] fc_before, input logic [15:0] fc_after,
                             input logic te, input logic [3:0] es);
    logic [3:0] seq [11];
    seq = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    for (int i = 0; i < 11; i++) begin
      cyc("quick_frame", 8'h7F, seq[i], (i == 10) ? fc_after : fc_before, te, es);
    end
  endtask

  initial begin
    drive(8'h00);
    rst_n = 1'b0;

    // Reset held three cycles: init strobe only, all counters cleared.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push(4'd0, 16'd0, 1'b0, 4'd0);
      check("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Init hold, idle wait, one paced frame, then a frame with draw_map_done
    // stuck high from GEN_MOVE onward.
    tbl.push_back(mk(8'h00, 4'd0, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd0, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd0, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd1, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h3F, 4'd1, 16'd0, 1'b0, 4'd0)); // stray dones in IDLE
    tbl.push_back(mk(8'h40, 4'd2, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd2, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h20, 4'd3, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd3, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h10, 4'd4, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd4, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd5, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd5, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd6, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd6, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h08, 4'd7, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd7, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h04, 4'd8, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd8, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h02, 4'd9, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h00, 4'd9, 16'd0, 1'b0, 4'd0));
    tbl.push_back(mk(8'h01, 4'd1, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h48, 4'd2, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h28, 4'd3, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h18, 4'd4, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h08, 4'd4, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h08, 4'd5, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h08, 4'd5, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h08, 4'd6, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h08, 4'd7, 16'd1, 1'b0, 4'd0)); // DRAW_MAP lasts 1 cycle
    tbl.push_back(mk(8'h04, 4'd8, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h02, 4'd9, 16'd1, 1'b0, 4'd0));
    tbl.push_back(mk(8'h01, 4'd1, 16'd2, 1'b0, 4'd0));
    foreach (tbl[i]) begin
      cyc("table", tbl[i].in, tbl[i].st, tbl[i].fc, tbl[i].te, tbl[i].es);
    end

    // Pause blocks leaving IDLE even with idle_done high.
    for (int i = 0; i < 50; i++) cyc("pause_hold", 8'hC0, 4'd1, 16'd2, 1'b0, 4'd0);
    cyc("pause_release", 8'h40, 4'd2, 16'd2, 1'b0, 4'd0);

    // Walk to DRAW_LINK, then starve it until the watchdog fires.
    cyc("to_link", 8'h20, 4'd3, 16'd2, 1'b0, 4'd0);
    cyc("to_link", 8'h10, 4'd4, 16'd2, 1'b0, 4'd0);
    cyc("to_link", 8'h00, 4'd4, 16'd2, 1'b0, 4'd0);
    cyc("to_link", 8'h00, 4'd5, 16'd2, 1'b0, 4'd0);
    cyc("to_link", 8'h00, 4'd5, 16'd2, 1'b0, 4'd0);
    cyc("to_link", 8'h00, 4'd6, 16'd2, 1'b0, 4'd0);
    cyc("to_link", 8'h08, 4'd7, 16'd2, 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) cyc("link_wait", 8'h00, 4'd7, 16'd2, 1'b0, 4'd0);
    cyc("link_timeout", 8'h00, 4'd1, 16'd2, 1'b1, 4'd7);

    // Done arriving on the last watchdog cycle still advances the frame.
    cyc("to_ene", 8'h40, 4'd2, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h20, 4'd3, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h10, 4'd4, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h00, 4'd4, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h00, 4'd5, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h00, 4'd5, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h00, 4'd6, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h08, 4'd7, 16'd2, 1'b1, 4'd7);
    cyc("to_ene", 8'h04, 4'd8, 16'd2, 1'b1, 4'd7);
    for (int i = 0; i < 15; i++) cyc("ene_wait", 8'h00, 4'd8, 16'd2, 1'b1, 4'd7);
    cyc("ene_done_wins", 8'h02, 4'd9, 16'd2, 1'b1, 4'd7);
    cyc("vga_done", 8'h01, 4'd1, 16'd3, 1'b1, 4'd7);

    // frame_count rolls over after the wrap value, then counts on.
    quick_frame(16'd3, 16'd0, 1'b1, 4'd7);
    quick_frame(16'd0, 16'd1, 1'b1, 4'd7);

    // Reset in the middle of DRAW_VGA takes effect without a clock edge.
    cyc("to_vga", 8'h40, 4'd2, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd3, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd4, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd4, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd5, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd5, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd6, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd7, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd8, 16'd1, 1'b1, 4'd7);
    cyc("to_vga", 8'h3E, 4'd9, 16'd1, 1'b1, 4'd7);
    cyc("vga_wait", 8'h00, 4'd9, 16'd1, 1'b1, 4'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push(4'd0, 16'd0, 1'b0, 4'd0);
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00);
    for (int i = 0; i < 3; i++) cyc("reinit", 8'h00, 4'd0, 16'd0, 1'b0, 4'd0);
    cyc("reinit_idle", 8'h00, 4'd1, 16'd0, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
